// File: rtl/apci_pci_pkg.sv
// Shared PCI definitions for the AmigaPCI arbiters.
package apci_pci_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PARK  = 2'b01,
    GRANT = 2'b10,
    BUSY  = 2'b11
  } arb_state_t;

  // Agent index of the host initiator (one past the last slot)
  localparam int unsigned HOST_AGENT    = 4;
  // Idle clocks a granted slot may waste before losing its grant
  localparam int unsigned DEAD_CLKS_DEF = 16;

endpackage

// File: rtl/pci_rr_select.sv
// Combinational round-robin priority encoder: the search starts one past ptr
// and wraps modulo N; the first active request wins.
module pci_rr_select #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] winner
);

  // Scan from the farthest candidate to the nearest so the nearest active one overwrites
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin between slot masters and the host,
// parks on the host when idle, revokes grants from masters that never start.
module pci_bus_arbiter
  import apci_pci_pkg::*;
#(
  parameter int unsigned NUM_REQ   = HOST_AGENT,
  parameter int unsigned DEAD_CLKS = DEAD_CLKS_DEF,
  parameter int unsigned OW        = 3
) (
  input  logic               CLK33,
  input  logic               RESETn,
  input  logic [NUM_REQ-1:0] REQn,
  input  logic               HOST_REQn,
  input  logic               FRAMEn,
  input  logic               IRDYn,
  output logic [NUM_REQ-1:0] GNTn,
  output logic               HOST_GNTn,
  output logic [OW-1:0]      BUS_OWNER,
  output logic               BUS_BUSY,
  output logic               DEAD_MASTER
);

  localparam int unsigned TW = (DEAD_CLKS > 1) ? $clog2(DEAD_CLKS) : 1;

  arb_state_t         state, state_next;
  logic [OW-1:0]      ptr, ptr_next, owner_next;
  logic [TW-1:0]      timer, timer_next;
  logic [NUM_REQ-1:0] gnt_next;
  logic               host_gnt_next, dead_next;
  logic [NUM_REQ:0]   agents;
  logic               bus_idle, owner_req, rr_valid;
  logic [OW-1:0]      rr_winner;

  assign agents    = {~HOST_REQn, ~REQn};
  assign bus_idle  = FRAMEn & IRDYn;
  assign owner_req = agents[BUS_OWNER];

  pci_rr_select #(
    .N (NUM_REQ + 1),
    .IW(OW)
  ) u_rr (
    .req   (agents),
    .ptr   (ptr),
    .valid (rr_valid),
    .winner(rr_winner)
  );

  // Next-state, pointer/timer updates and registered-grant decode
  always_comb begin
    state_next = state;
    owner_next = BUS_OWNER;
    ptr_next   = ptr;
    timer_next = timer;
    dead_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus_idle) begin
          if (rr_valid) begin
            state_next = GRANT;
            owner_next = rr_winner;
            timer_next = '0;
          end else begin
            state_next = PARK;
            owner_next = OW'(NUM_REQ);
          end
        end
      end
      PARK: begin
        if (!FRAMEn) begin
          state_next = BUSY;
          ptr_next   = OW'(NUM_REQ);
        end else if (REQn != '1) begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (!FRAMEn) begin
          state_next = BUSY;
          ptr_next   = BUS_OWNER;
        end else if (!owner_req) begin
          state_next = IDLE;
        end else if (timer == TW'(DEAD_CLKS - 1)) begin
          state_next = IDLE;
          dead_next  = 1'b1;
          ptr_next   = BUS_OWNER;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      BUSY: begin
        if (bus_idle) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Grants are a function of where we land, so they can be registered directly
    gnt_next = '1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_next[i] = !(state_next == GRANT && owner_next == OW'(i));
    end
    host_gnt_next = !(state_next == PARK ||
                      (state_next == GRANT && owner_next == OW'(NUM_REQ)));
  end

  // State register and registered outputs
  always_ff @(posedge CLK33) begin
    if (!RESETn) begin
      state       <= IDLE;
      ptr         <= OW'(NUM_REQ);
      timer       <= '0;
      GNTn        <= '1;
      HOST_GNTn   <= 1'b1;
      BUS_OWNER   <= OW'(NUM_REQ);
      BUS_BUSY    <= 1'b0;
      DEAD_MASTER <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      timer       <= timer_next;
      GNTn        <= gnt_next;
      HOST_GNTn   <= host_gnt_next;
      BUS_OWNER   <= owner_next;
      BUS_BUSY    <= (state_next == BUSY);
      DEAD_MASTER <= dead_next;
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: directed scenarios plus a random
// run, all compared every clock against a behavioural model of bus ownership.
module tb_pci_bus_arbiter;

  localparam int NR = 4;
  localparam int DC = 16;

  logic          CLK33 = 1'b0;
  logic          RESETn = 1'b0;
  logic [NR-1:0] REQn = '1;
  logic          HOST_REQn = 1'b1;
  logic          FRAMEn = 1'b1;
  logic          IRDYn = 1'b1;
  logic [NR-1:0] GNTn;
  logic          HOST_GNTn;
  logic [2:0]    BUS_OWNER;
  logic          BUS_BUSY;
  logic          DEAD_MASTER;
  logic [9:0]    obs;

  int total = 0;
  int bad = 0;

  pci_bus_arbiter #(.NUM_REQ(NR), .DEAD_CLKS(DC), .OW(3)) dut (
    .CLK33(CLK33), .RESETn(RESETn), .REQn(REQn), .HOST_REQn(HOST_REQn),
    .FRAMEn(FRAMEn), .IRDYn(IRDYn), .GNTn(GNTn), .HOST_GNTn(HOST_GNTn),
    .BUS_OWNER(BUS_OWNER), .BUS_BUSY(BUS_BUSY), .DEAD_MASTER(DEAD_MASTER)
  );

  always #5 CLK33 = ~CLK33;

  assign obs = {GNTn, HOST_GNTn, BUS_OWNER, BUS_BUSY, DEAD_MASTER};

  // Model: who holds a grant (-1 nobody), whether the host merely parks,
  // whether a transaction owns the bus, and the fairness bookkeeping.
  int m_grant = -1;
  bit m_parked = 0, m_txn = 0, m_dead = 0;
  int m_owner = NR, m_last = NR, m_wasted = 0;

  function automatic bit wants(int a);
    return (a == NR) ? !HOST_REQn : !REQn[a];
  endfunction

  task automatic model_step();
    bit idle;
    idle = FRAMEn & IRDYn;
    m_dead = 0;
    if (!RESETn) begin
      m_grant = -1; m_parked = 0; m_txn = 0; m_owner = NR; m_last = NR; m_wasted = 0;
    end else if (m_txn) begin
      if (idle) m_txn = 0;
    end else if (m_grant < 0) begin
      if (idle) begin
        m_grant = NR; m_parked = 1; m_owner = NR;
        for (int k = NR + 1; k >= 1; k--) begin
          if (wants((m_last + k) % (NR + 1))) begin
            m_grant = (m_last + k) % (NR + 1);
            m_parked = 0;
          end
        end
        m_owner = m_grant;
        m_wasted = 0;
      end
    end else if (m_parked) begin
      if (!FRAMEn) begin
        m_grant = -1; m_parked = 0; m_txn = 1; m_last = NR;
      end else if (REQn != '1) begin
        m_grant = -1; m_parked = 0;
      end
    end else begin
      if (!FRAMEn) begin
        m_txn = 1; m_last = m_grant; m_grant = -1;
      end else if (!wants(m_grant)) begin
        m_grant = -1;
      end else if (m_wasted + 1 == DC) begin
        m_dead = 1; m_last = m_grant; m_grant = -1;
      end else begin
        m_wasted++;
      end
    end
  endtask

  function automatic logic [9:0] expv();
    logic [NR-1:0] g;
    g = '1;
    if (m_grant >= 0 && m_grant < NR) g[m_grant] = 1'b0;
    return {g, (m_grant != NR), 3'(m_owner), m_txn, m_dead};
  endfunction

  task automatic tick();
    @(posedge CLK33);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (2) tick();
    total++;
    if (obs !== 10'b1111_1_100_0_0) begin
      bad++; $display("FAIL reset_values obs=%b exp=%b", obs, 10'b1111_1_100_0_0);
    end
    RESETn = 1'b1;
    tick();
    total++;
    if (HOST_GNTn !== 1'b0 || GNTn !== 4'hF || BUS_OWNER !== 3'd4) begin
      bad++; $display("FAIL park_after_reset host=%b gnt=%b owner=%0d exp 0/1111/4", HOST_GNTn, GNTn, BUS_OWNER);
    end
  endtask

  task automatic test_host_txn();
    FRAMEn = 1'b0; IRDYn = 1'b0;
    tick();
    total++;
    if (BUS_BUSY !== 1'b1 || HOST_GNTn !== 1'b1) begin
      bad++; $display("FAIL host_busy busy=%b host=%b exp 1/1", BUS_BUSY, HOST_GNTn);
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 2) FRAMEn = 1'b1;
      if (c == 3) IRDYn = 1'b1;
      tick();
      total++;
      if (obs !== expv()) begin
        bad++; $display("FAIL host_txn_model obs=%b exp=%b", obs, expv());
      end
    end
    total++;
    if (BUS_BUSY !== 1'b0 || HOST_GNTn !== 1'b1) begin
      bad++; $display("FAIL host_idle_gap busy=%b host=%b exp 0/1", BUS_BUSY, HOST_GNTn);
    end
    tick();
    total++;
    if (HOST_GNTn !== 1'b0) begin
      bad++; $display("FAIL host_repark host=%b exp 0", HOST_GNTn);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int run = 0;
    logic [NR-1:0] prev = '1;
    REQn = 4'b0101;
    for (int c = 0; c < 60 && order.size() < 3; c++) begin
      tick();
      total++;
      if (obs !== expv()) begin
        bad++; $display("FAIL rr_model obs=%b exp=%b", obs, expv());
      end
      if (GNTn !== 4'hF && prev !== 4'hF && GNTn !== prev) begin
        total++; bad++; $display("FAIL rr_turnaround prev=%b now=%b exp all-high between", prev, GNTn);
      end
      if (run > 0) begin
        run--;
        if (run == 0) begin FRAMEn = 1'b1; IRDYn = 1'b1; end
      end else if (GNTn !== 4'hF) begin
        for (int i = 0; i < NR; i++) if (!GNTn[i]) order.push_back(i);
        FRAMEn = 1'b0; IRDYn = 1'b0; run = 4;
      end
      prev = GNTn;
    end
    total++;
    if (order.size() != 3) begin
      bad++; $display("FAIL rr_count got=%0d exp=3", order.size());
    end else if (order[0] != 1 || order[1] != 3 || order[2] != 1) begin
      bad++; $display("FAIL rr_order got=%0d,%0d,%0d exp=1,3,1", order[0], order[1], order[2]);
    end
    REQn = '1;
    repeat (run) tick();
    FRAMEn = 1'b1; IRDYn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (obs !== expv()) begin
        bad++; $display("FAIL rr_drain_model obs=%b exp=%b", obs, expv());
      end
    end
  endtask

  task automatic test_dead_master();
    int held = 0, pulses = 0;
    bit got_next = 0;
    REQn = 4'b1101;
    repeat (2) tick();
    total++;
    if (GNTn !== 4'b1101) begin
      bad++; $display("FAIL dead_first_grant gnt=%b exp=1101", GNTn);
    end
    REQn = 4'b0101;
    for (int c = 0; c < 40 && !got_next; c++) begin
      if (!GNTn[1]) held++;
      tick();
      if (DEAD_MASTER) pulses++;
      total++;
      if (obs !== expv()) begin
        bad++; $display("FAIL dead_model obs=%b exp=%b", obs, expv());
      end
      if (GNTn !== 4'hF && GNTn[1]) begin
        got_next = 1;
        total++;
        if (GNTn !== 4'b0111) begin
          bad++; $display("FAIL dead_next_grant gnt=%b exp=0111", GNTn);
        end
      end
    end
    total++;
    if (held != DC || pulses != 1 || !got_next) begin
      bad++; $display("FAIL dead_timeout held=%0d pulses=%0d next=%0d exp %0d/1/1", held, pulses, got_next, DC);
    end
  endtask

  task automatic test_req_drop();
    repeat (2) tick();
    REQn = '1;
    tick();
    total++;
    if (GNTn !== 4'hF || DEAD_MASTER !== 1'b0 || HOST_GNTn !== 1'b1) begin
      bad++; $display("FAIL drop_idle gnt=%b dead=%b host=%b exp 1111/0/1", GNTn, DEAD_MASTER, HOST_GNTn);
    end
    tick();
    total++;
    if (HOST_GNTn !== 1'b0 || BUS_OWNER !== 3'd4 || obs !== expv()) begin
      bad++; $display("FAIL drop_park obs=%b exp=%b", obs, expv());
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 2; s++) begin
      REQn = (s == 0) ? 4'b1110 : 4'b1011;
      for (int c = 0; c < 6 && GNTn === 4'hF; c++) tick();
      total++;
      if (GNTn !== ((s == 0) ? 4'b1110 : 4'b1011)) begin
        bad++; $display("FAIL rst_setup%0d gnt=%b", s, GNTn);
      end
      if (s == 0) begin
        FRAMEn = 1'b0; IRDYn = 1'b0;
        tick();
        total++;
        if (BUS_BUSY !== 1'b1) begin
          bad++; $display("FAIL rst_busy busy=%b exp 1", BUS_BUSY);
        end
      end
      RESETn = 1'b0;
      tick();
      total++;
      if (obs !== 10'b1111_1_100_0_0) begin
        bad++; $display("FAIL rst_mid%0d obs=%b exp=%b", s, obs, 10'b1111_1_100_0_0);
      end
      RESETn = 1'b1; FRAMEn = 1'b1; IRDYn = 1'b1; REQn = '1;
      repeat (2) tick();
    end
  endtask

  task automatic test_random();
    int txn = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) REQn[i] = ($urandom_range(2) != 0);
      HOST_REQn = ($urandom_range(3) != 0);
      RESETn = ($urandom_range(199) != 0);
      if (txn > 0) begin
        txn--;
        FRAMEn = (txn == 0);
        IRDYn = 1'b0;
      end else if ($urandom_range(5) == 0) begin
        txn = $urandom_range(6, 1);
        FRAMEn = 1'b0; IRDYn = 1'b0;
      end else begin
        FRAMEn = 1'b1; IRDYn = 1'b1;
      end
      tick();
      total++;
      if (obs !== expv()) begin
        bad++; $display("FAIL random_model cyc=%0d obs=%b exp=%b", c, obs, expv());
      end
      if ($countones({GNTn, HOST_GNTn}) < NR) begin
        total++; bad++; $display("FAIL one_grant cyc=%0d gnt=%b host=%b exp at most one low", c, GNTn, HOST_GNTn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_host_txn();
    test_round_robin();
    test_dead_master();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
